mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the core's single synchronous memory port between the instruction-fetch requester and the load/store requester of the multicycle control FSM. Each requester uses a req/gnt/rvalid handshake. The arbiter serialises accesses, drives the memory command signals and routes read data back to the originating port. It sits between `control` and the memory model/SRAM and owns all memory-side signals.

## Interface
- `RD_LAT_P`, default 1: memory read latency in cycles, from the cycle `rd_en_o` is high to the cycle `mem_data_i` is valid. Legal range 1–7.
- `clk_i`, input, 1: single clock; all logic is on the rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `if_req_i`, input, 1: fetch read request. Held until `if_gnt_o`.
- `if_addr_i`, input, `byte_addr_p`: fetch byte address.
- `if_gnt_o`, output, 1: one-cycle pulse; the fetch command has been issued.
- `if_rvalid_o`, output, 1: one-cycle pulse; `if_rdata_o` is valid.
- `if_rdata_o`, output, 32: fetched word.
- `d_req_i`, input, 1: data request. Held until `d_gnt_o`.
- `d_we_i`, input, 1: 1 = store, 0 = load.
- `d_be_i`, input, 4: byte enables for stores; ignored for loads.
- `d_addr_i`, input, `byte_addr_p`: data byte address.
- `d_wdata_i`, input, 32: store data, byte-lane aligned.
- `d_gnt_o`, output, 1: one-cycle pulse; the data command has been issued.
- `d_rvalid_o`, output, 1: one-cycle pulse; `d_rdata_o` is valid.
- `d_rdata_o`, output, 32: load word.
- `addr_o`, output, `byte_addr_p`: memory word address; bits [1:0] are always 0.
- `rd_en_o`, output, 1: memory read strobe.
- `wr_en_o`, output, 1: memory write strobe.
- `be_o`, output, 4: memory byte enables.
- `mem_data_o`, output, 32: memory write data.
- `mem_data_i`, input, 32: memory read data.
- `busy_o`, output, 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, WRITE, READ_WAIT, RESP. Only one transaction is outstanding at a time.
- **IDLE:** if any request is pending, select a winner. Data has fixed priority over fetch.
- On the edge that selects a winner, register the command signals, the winner's `*_gnt_o` pulse and the `owner` flag:
  - `addr_o` = winner's address with bits [1:0] cleared.
  - `be_o` = `d_be_i` for a data store; `4'hF` for any read.
  - `mem_data_o` = `d_wdata_i` for a store.
- Next state after selection: WRITE for a store; READ_WAIT for a read, with the latency counter loaded to `RD_LAT_P`.
- **WRITE:** `wr_en_o` = 1 for exactly this cycle. Next state is IDLE.
- **READ_WAIT:**
  - `rd_en_o` = 1 in the first cycle only.
  - The counter decrements each cycle.
  - When the counter reaches 0, capture `mem_data_i` into the rdata register of `owner` and go to RESP.
- **RESP:** the owner's `*_rvalid_o` = 1 for one cycle. Next state is IDLE.
- `*_rdata_o` holds its last captured value until the next capture for that port. The other port's rdata is never modified.
- Requester rule: after seeing `gnt`, the requester drops or updates `req` on the next edge. The arbiter never samples requests in the cycle in which `gnt` is visible.
- Reset value of every output: 0 (`addr_o`, `be_o`, `mem_data_o`, both rdata registers, all strobes, all gnt/rvalid, `busy_o`). State resets to IDLE and `owner` to fetch.
- Reset mid-transaction: the transaction is abandoned. No `gnt` or `rvalid` is produced afterwards. Requesters re-request after reset.
- Requests arriving while busy are not lost. They stay pending, because `req` is held, and are arbitrated on return to IDLE.

## Timing
- Request sampled high in IDLE in cycle N:
  - `gnt` and the command are visible in cycle N+1.
  - A store completes in N+1 (`wr_en_o` high); the next request can be sampled in N+2.
  - A read has `rd_en_o` high in N+1; `mem_data_i` is captured at the end of N+RD_LAT_P+1; `rvalid` is high in N+RD_LAT_P+2; the next sample is in N+RD_LAT_P+2.
- Read request-to-rvalid latency is `RD_LAT_P`+2 cycles (3 with the default). Read throughput is one per `RD_LAT_P`+2 cycles. Store throughput is one per 2 cycles.
- `rd_en_o` and `wr_en_o` are never high in the same cycle. At most one `gnt` and at most one `rvalid` is high per cycle.

## Structure
- Add to `riscv_pkg`:
  - `t_arb_state` enum with IDLE, WRITE, READ_WAIT, RESP.
  - `t_mem_port` enum with PORT_IF, PORT_D.
  - `byte_addr_p`, already present.
- Flat module with no sub-module. The latency counter is 3 bits, sized for `RD_LAT_P` ≤ 7.

## Test plan
- Fetch only, `if_addr_i`=0x10, memory word 0x00000013:
  - `rd_en_o` high with `addr_o`=0x10 in cycle N+1.
  - `if_rvalid_o` high in N+3 with `if_rdata_o`=0x00000013.
  - `d_rvalid_o` never asserts.
- Simultaneous `if_req_i` and `d_req_i` (load @0x24) in IDLE:
  - `d_gnt_o` in N+1.
  - `if_gnt_o` in N+4.
  - Data rvalid precedes fetch rvalid.
- Store `d_be_i`=4'b0100, `d_addr_i`=0x2E, `d_wdata_i`=0x00AB0000:
  - `wr_en_o` high for one cycle with `addr_o`=0x2C, `be_o`=4'b0100.
  - The following load of 0x2C returns 0x00AB0000 in byte 2.
- `RD_LAT_P`=3, fetch @0x40: `if_rvalid_o` in N+5, and the counter behaves correctly across the wait.
- `rst_i` asserted in READ_WAIT: all outputs are 0 in the following cycle, no `rvalid` ever appears, and a fresh request after reset is served normally.
- Back-to-back stores from `d_req_i` held with new addresses each grant: `wr_en_o` pattern is 1,0,1,0, and `busy_o` alternates accordingly.

Source files
------------

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared types and constants for the core.
//   - byte_addr_p : width of a byte address on the core's buses.
//   - t_arb_state : states of the memory port arbiter.
//   - t_mem_port  : identifies which requester owns the memory port.
//   - word_align  : clears the byte-offset bits of a byte address.
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned byte_addr_p = 32;

    // Byte enables used for every read: the whole word is returned.
    localparam logic [3:0] be_all_c = 4'hF;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITE     = 2'd1,
        READ_WAIT = 2'd2,
        RESP      = 2'd3
    } t_arb_state;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } t_mem_port;

    function automatic logic [byte_addr_p-1:0] word_align(input logic [byte_addr_p-1:0] a);
        return a & {{(byte_addr_p-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Shares the single synchronous memory port between instruction fetch and
//   load/store. One transaction is outstanding at a time; data requests win
//   over fetch requests. Read data is routed back to the requester that owns
//   the transaction.
//
//   Handshake (both requesters): the requester raises *_req_i and holds it
//   with stable command fields until it sees the one-cycle *_gnt_o pulse,
//   then drops or changes the request on the following edge. For reads, a
//   one-cycle *_rvalid_o pulse later marks *_rdata_o valid; *_rdata_o keeps
//   that value until the next read for the same port completes.
//
//   Ports
//     clk_i, rst_i                 clock, synchronous active-high reset
//     if_req_i/if_addr_i           fetch request and byte address
//     if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant, read-valid, fetched word
//     d_req_i/d_we_i/d_be_i/d_addr_i/d_wdata_i  data request fields
//     d_gnt_o/d_rvalid_o/d_rdata_o  data grant, read-valid, load word
//     addr_o/rd_en_o/wr_en_o/be_o/mem_data_o  memory command (registered)
//     mem_data_i                   memory read data, RD_LAT_P cycles after rd_en_o
//     busy_o                       high whenever the arbiter is not IDLE
//     dbg_state_o                  current arbiter state, for observation
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned RD_LAT_P = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   if_req_i,
    input  logic [byte_addr_p-1:0] if_addr_i,
    output logic                   if_gnt_o,
    output logic                   if_rvalid_o,
    output logic [31:0]            if_rdata_o,

    input  logic                   d_req_i,
    input  logic                   d_we_i,
    input  logic [3:0]             d_be_i,
    input  logic [byte_addr_p-1:0] d_addr_i,
    input  logic [31:0]            d_wdata_i,
    output logic                   d_gnt_o,
    output logic                   d_rvalid_o,
    output logic [31:0]            d_rdata_o,

    output logic [byte_addr_p-1:0] addr_o,
    output logic                   rd_en_o,
    output logic                   wr_en_o,
    output logic [3:0]             be_o,
    output logic [31:0]            mem_data_o,
    input  logic [31:0]            mem_data_i,

    output logic                   busy_o,
    output t_arb_state             dbg_state_o
);

    t_arb_state             state_q;
    t_mem_port              owner_q;
    logic [2:0]             cnt_q;

    logic [byte_addr_p-1:0] addr_q;
    logic [3:0]             be_q;
    logic [31:0]            mem_data_q;
    logic                   rd_en_q;
    logic                   wr_en_q;
    logic                   if_gnt_q;
    logic                   d_gnt_q;
    logic                   if_rvalid_q;
    logic                   d_rvalid_q;
    logic [31:0]            if_rdata_q;
    logic [31:0]            d_rdata_q;

    // Arbitration result for the current cycle; only acted on when the
    // FSM is free to start a new transaction.
    logic                   win_valid_d;
    t_mem_port              win_port_d;
    logic                   win_store_d;
    logic [byte_addr_p-1:0] win_addr_d;

    always_comb begin
        win_valid_d = d_req_i | if_req_i;
        win_port_d  = d_req_i ? PORT_D : PORT_IF;
        win_store_d = d_req_i & d_we_i;
        win_addr_d  = word_align(d_req_i ? d_addr_i : if_addr_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= PORT_IF;
            cnt_q       <= 3'd0;
            addr_q      <= '0;
            be_q        <= 4'h0;
            mem_data_q  <= 32'h0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
        end else begin
            // Strobes and pulses are single-cycle unless re-armed below.
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;

            case (state_q)
                // RESP also arbitrates: the gnt of the finishing read is long
                // gone, so the next request can be taken in the rvalid cycle,
                // which gives one read per RD_LAT_P+2 cycles.
                IDLE, RESP: begin
                    state_q <= IDLE;
                    if (win_valid_d) begin
                        owner_q <= win_port_d;
                        addr_q  <= win_addr_d;
                        if (win_port_d == PORT_D) begin
                            d_gnt_q <= 1'b1;
                        end else begin
                            if_gnt_q <= 1'b1;
                        end
                        if (win_store_d) begin
                            be_q       <= d_be_i;
                            mem_data_q <= d_wdata_i;
                            wr_en_q    <= 1'b1;
                            state_q    <= WRITE;
                        end else begin
                            // mem_data_o keeps the last store data on reads.
                            be_q    <= be_all_c;
                            rd_en_q <= 1'b1;
                            cnt_q   <= 3'(RD_LAT_P);
                            state_q <= READ_WAIT;
                        end
                    end
                end

                WRITE: begin
                    state_q <= IDLE;
                end

                READ_WAIT: begin
                    // Counter is RD_LAT_P in the rd_en_o cycle, so it reaches
                    // zero exactly in the cycle mem_data_i is valid.
                    if (cnt_q == 3'd0) begin
                        if (owner_q == PORT_D) begin
                            d_rdata_q  <= mem_data_i;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_data_i;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr_o      = addr_q;
    assign be_o        = be_q;
    assign mem_data_o  = mem_data_q;
    assign rd_en_o     = rd_en_q;
    assign wr_en_o     = wr_en_q;
    assign if_gnt_o    = if_gnt_q;
    assign d_gnt_o     = d_gnt_q;
    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;
    assign busy_o      = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule
